// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART defaults and one-hot receiver state encoding
package uart_rx_pkg;
  localparam int NB_DATA_DEF = 8;
  localparam int N_OVERSAMPLE_DEF = 16;
  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    BRK   = 5'b10000
  } rx_state_t;
endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchronizer for an asynchronous input with selectable reset value
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge i_clock) begin
    if (i_reset) {q, meta} <= {RST_VAL, RST_VAL};
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with stop-bit frame error detection
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int N_OVERSAMPLE = N_OVERSAMPLE_DEF,
  parameter int NB_STOP = 1
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_tick,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_data_valid,
  output logic               o_frame_error
);
  localparam int NB_TICK = $clog2(N_OVERSAMPLE);
  localparam int NB_BIT = $clog2(NB_DATA + 1);
  localparam logic [NB_TICK-1:0] HALF = NB_TICK'(N_OVERSAMPLE / 2 - 1);
  localparam logic [NB_TICK-1:0] LAST = NB_TICK'(N_OVERSAMPLE - 1);
  localparam logic [NB_BIT-1:0] LAST_DATA = NB_BIT'(NB_DATA - 1);
  localparam logic [NB_BIT-1:0] LAST_STOP = NB_BIT'(NB_STOP - 1);
  rx_state_t state;
  logic [NB_TICK-1:0] tick_cnt;
  logic [NB_BIT-1:0] bit_cnt;
  logic [NB_DATA-1:0] shreg;
  logic rx_s;
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .d(i_rx),
    .q(rx_s)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      o_data <= '0;
      o_data_valid <= 1'b0;
      o_frame_error <= 1'b0;
    end else begin
      o_data_valid <= 1'b0;
      o_frame_error <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          tick_cnt <= '0;
        end
        START: if (i_tick) begin
          if (tick_cnt == HALF) begin
            state <= rx_s ? IDLE : DATA;
            tick_cnt <= '0;
            bit_cnt <= '0;
          end else tick_cnt <= tick_cnt + 1'b1;
        end
        DATA: if (i_tick) begin
          if (tick_cnt == LAST) begin
            shreg <= {rx_s, shreg[NB_DATA-1:1]};
            tick_cnt <= '0;
            bit_cnt <= (bit_cnt == LAST_DATA) ? '0 : bit_cnt + 1'b1;
            if (bit_cnt == LAST_DATA) state <= STOP;
          end else tick_cnt <= tick_cnt + 1'b1;
        end
        STOP: if (i_tick) begin
          if (tick_cnt == LAST) begin
            if (!rx_s) begin
              state <= BRK;
              o_frame_error <= 1'b1;
            end else if (bit_cnt == LAST_STOP) begin
              state <= IDLE;
              o_data <= shreg;
              o_data_valid <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tick_cnt <= '0;
            end
          end else tick_cnt <= tick_cnt + 1'b1;
        end
        BRK: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed checks of uart_rx against a frame-level model
module tb_uart_rx;
  logic clk = 0, rst = 1, rx = 1, rx2 = 1, tick = 0;
  logic [7:0] d1, d2;
  logic v1, v2, f1, f2;
  int div = 1, cyc = 0, t_start = 0, t_ev = -1, both = 0, n_chk = 0, n_err = 0, lat;
  int q1[$], q2[$], e1[$], e2[$];
  logic [7:0] good1 = 0, good2 = 0;
  uart_rx #(.NB_STOP(1)) dut (
    .i_clock(clk), .i_reset(rst), .i_rx(rx), .i_tick(tick),
    .o_data(d1), .o_data_valid(v1), .o_frame_error(f1)
  );
  uart_rx #(.NB_STOP(2)) dut2 (
    .i_clock(clk), .i_reset(rst), .i_rx(rx2), .i_tick(tick),
    .o_data(d2), .o_data_valid(v2), .o_frame_error(f2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin : tickgen
    int tc;
    tc = 0;
    forever begin
      @(negedge clk);
      tick = (tc == 0);
      tc = (tc + 1) % div;
    end
  end
  always @(negedge clk) begin
    if (!rst) begin
      if (v1) begin
        q1.push_back(int'(d1));
        if (t_ev < 0) t_ev = cyc;
      end
      if (f1) q1.push_back(256);
      if (v2) q2.push_back(int'(d2));
      if (f2) q2.push_back(256);
      if ((v1 && f1) || (v2 && f2)) both++;
    end
  end
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int expect_code(input logic [7:0] d, input logic [1:0] stops, input int nstop);
    for (int i = 0; i < nstop; i++) if (!stops[i]) return 256;
    return int'(d);
  endfunction
  task automatic drive_bit(input int sel, input logic b);
    if (sel == 2) rx2 = b;
    else rx = b;
    repeat (16 * div) @(negedge clk);
  endtask
  task automatic send_frame(input int sel, input logic [7:0] d, input logic [1:0] stops, input int gap);
    int code, ns;
    ns = (sel == 2) ? 2 : 1;
    t_start = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    for (int i = 0; i < ns; i++) drive_bit(sel, stops[i]);
    repeat (gap) drive_bit(sel, 1'b1);
    code = expect_code(d, stops, ns);
    if (sel == 2) begin
      e2.push_back(code);
      if (code < 256) good2 = d;
    end else begin
      e1.push_back(code);
      if (code < 256) good1 = d;
    end
  endtask
  task automatic compare(input string tag, input int sel);
    int q[$], e[$];
    repeat (64 * div) @(negedge clk);
    if (sel == 2) begin
      q = q2; e = e2; q2.delete(); e2.delete();
      chk({tag, "_data"}, int'(d2), int'(good2));
    end else begin
      q = q1; e = e1; q1.delete(); e1.delete();
      chk({tag, "_data"}, int'(d1), int'(good1));
    end
    chk({tag, "_events"}, q.size(), e.size());
    for (int i = 0; i < e.size() && i < q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), q[i], e[i]);
  endtask
  initial begin
    logic [7:0] d;
    logic [1:0] st;
    repeat (4) @(negedge clk);
    chk("rst_data", int'(d1), 0);
    chk("rst_valid", int'(v1), 0);
    chk("rst_ferr", int'(f1), 0);
    chk("rst_data2", int'(d2), 0);
    rst = 0;
    repeat (20) @(negedge clk);
    send_frame(1, 8'hA5, 2'b11, 0);
    compare("t1", 1);
    lat = t_ev - t_start;
    chk("t1_latency", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
    send_frame(1, 8'h00, 2'b11, 0);
    send_frame(1, 8'hFF, 2'b11, 2);
    compare("t2", 1);
    rx = 0;
    repeat (4) @(negedge clk);
    rx = 1;
    compare("t3", 1);
    send_frame(1, 8'h3C, 2'b00, 0);
    rx = 0;
    repeat (40 * 16) @(negedge clk);
    rx = 1;
    repeat (32) @(negedge clk);
    compare("t4_brk", 1);
    send_frame(1, 8'h5A, 2'b11, 2);
    compare("t4_rec", 1);
    d = 8'hC3;
    drive_bit(1, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1, d[i]);
    rx = d[3];
    repeat (8) @(negedge clk);
    rst = 1;
    rx = 1;
    repeat (3) @(negedge clk);
    good1 = 0;
    good2 = 0;
    chk("t5_data", int'(d1), 0);
    chk("t5_valid", int'(v1), 0);
    chk("t5_ferr", int'(f1), 0);
    rst = 0;
    compare("t5_abort", 1);
    send_frame(1, 8'h81, 2'b11, 2);
    compare("t5_rec", 1);
    div = 10;
    repeat (200) @(negedge clk);
    send_frame(1, 8'h6E, 2'b11, 2);
    compare("t6a", 1);
    send_frame(2, 8'h6E, 2'b11, 2);
    compare("t6b", 2);
    send_frame(2, 8'h6E, 2'b01, 2);
    compare("t6c", 2);
    for (int r = 0; r < 4; r++) begin
      div = (r == 0) ? 1 : $urandom_range(1, 3);
      repeat (32 * div) @(negedge clk);
      for (int k = 0; k < 10; k++) begin
        d = 8'($urandom);
        st = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b11;
        send_frame(1, d, st, st[0] ? $urandom_range(0, 2) : $urandom_range(1, 2));
      end
      compare($sformatf("rnd%0d", r), 1);
    end
    div = 1;
    repeat (32) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      d = 8'($urandom);
      st = ($urandom_range(0, 1) == 0) ? 2'(($urandom)) : 2'b11;
      send_frame(2, d, st, (st == 2'b11) ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end
    compare("rnd2", 2);
    chk("exclusive", both, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
